// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage constants and the PC alignment helper.
package instruction_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          ADDR_W_DEFAULT   = 16;
  localparam int          DATA_W_DEFAULT   = 32;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

  typedef logic [31:0] pc_t;

  function automatic pc_t align_pc(input pc_t pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// 2-entry {pc,instr} skid buffer between the imem response and decode.
// Latency: push visible at head next cycle; pop/flush take effect next cycle.
// Backpressure: none internal -- the caller's issue rule keeps occ+inflight <= 2.
module fetch_skid_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [31+DATA_W:0]   push_data,
  input  logic                 pop,
  input  logic                 flush,
  output logic                 head_valid,
  output logic [31+DATA_W:0]   head_data,
  output logic [1:0]           occ
);

  localparam logic [31+DATA_W:0] RST_ENTRY = {32'h0, DATA_W'(INSTR_NOP)};

  logic [31+DATA_W:0] slot0;
  logic [31+DATA_W:0] slot1;
  logic [1:0]         occ_q;
  logic               pop_ok;

  assign pop_ok     = pop && (occ_q != 2'd0);
  assign head_valid = (occ_q != 2'd0);
  assign head_data  = slot0;
  assign occ        = occ_q;

  // slot0 is always the head; a pop shifts slot1 forward.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q <= 2'd0;
      slot0 <= RST_ENTRY;
      slot1 <= RST_ENTRY;
    end else if (flush) begin
      occ_q <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (occ_q == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, one outstanding imem read, skid FIFO to decode.
// Latency: redirect/reset to first if_valid is 3 cycles; 1 instr/cycle steady state.
// Backpressure: id_ready low fills the FIFO to 2, then issue stops and pc_q freezes.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = ADDR_W_DEFAULT,
  parameter int          DATA_W   = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rd,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [31:0]       if_pc,
  input  logic              id_ready
);

  pc_t                pc_q;
  pc_t                inflight_pc;
  logic               inflight;
  logic [1:0]         occ;
  logic               deq;
  logic               issue;
  logic               push;
  logic [31+DATA_W:0] head_data;

  assign deq       = if_valid && id_ready;
  // A dequeue frees a slot this cycle, so issue may refill it without overflow.
  assign issue     = !redirect_valid && ((({1'b0, occ} + {2'b00, inflight}) < 3'd2) || deq);
  assign push      = inflight && !redirect_valid;
  assign imem_addr = pc_q[ADDR_W+1:2];
  assign if_pc     = head_data[31+DATA_W:DATA_W];
  assign if_instr  = head_data[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
    end else if (redirect_valid) begin
      pc_q     <= align_pc(redirect_pc);
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc_q;
        pc_q        <= pc_q + 32'd4;
      end
    end
  end

  fetch_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  ({inflight_pc, imem_rd}),
    .pop        (deq),
    .flush      (redirect_valid),
    .head_valid (if_valid),
    .head_data  (head_data),
    .occ        (occ)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: imem model, stream model checked every cycle, directed cases.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [15:0] imem_addr;
  logic [31:0] imem_rd = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready)
  );

  function automatic logic [31:0] word_of_addr(input logic [15:0] a);
    return 32'hA000_0000 + {16'h0, a};
  endfunction

  function automatic logic [31:0] word_of_pc(input logic [31:0] pc);
    return word_of_addr(pc[17:2]);
  endfunction

  // Synchronous 64K-word memory, word k = A000_0000 + k.
  always @(posedge clk) imem_rd <= word_of_addr(imem_addr);

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Stream model: valid from the 3rd cycle after a reset/redirect, then the
  // head walks +4 from the target on each acceptance.
  int          age = 0;
  logic [31:0] exp_pc = 32'h0;
  int          accepted = 0;
  logic [31:0] last_acc_pc = 32'h0;

  always @(negedge clk) begin
    if (!rst_n) begin
      age    = 0;
      exp_pc = 32'h0;
    end else begin
      if (age < 1000) age++;
      if (age >= 3) begin
        check32("model_valid", 32'(if_valid), 32'd1);
        check32("model_pc", if_pc, exp_pc);
        check32("model_instr", if_instr, word_of_pc(exp_pc));
      end else begin
        check32("model_idle", 32'(if_valid), 32'd0);
      end
      if (if_valid && id_ready) begin
        accepted++;
        last_acc_pc = if_pc;
      end
      if (redirect_valid) begin
        age    = 0;
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (age >= 3 && id_ready) begin
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  logic [15:0] pattern;
  int          acc0;

  initial begin
    repeat (3) step();
    check32("rst_valid", 32'(if_valid), 32'd0);
    check32("rst_pc", if_pc, 32'h0);
    check32("rst_instr", if_instr, 32'h0);
    check32("rst_addr", 32'(imem_addr), 32'h0);

    // first fetch latency and steady stream
    rst_n = 1'b1;
    step();
    check32("t1_cyc2_valid", 32'(if_valid), 32'd0);
    step();
    check32("t1_cyc3_valid", 32'(if_valid), 32'd1);
    check32("t1_pc0", if_pc, 32'h0);
    check32("t1_instr0", if_instr, 32'hA000_0000);
    step();
    check32("t1_pc1", if_pc, 32'h4);
    check32("t1_instr1", if_instr, 32'hA000_0001);
    step();
    check32("t1_pc2", if_pc, 32'h8);
    check32("t1_instr2", if_instr, 32'hA000_0002);
    check32("t2_addr_before", 32'(imem_addr), 32'd4);

    // stall for 5 cycles
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check32("t2_pc_frozen", if_pc, 32'h8);
    end
    check32("t2_occ", 32'(dut.occ), 32'd2);
    check32("t2_addr_adv", 32'((imem_addr - 16'd4) <= 16'd1), 32'd1);
    id_ready = 1'b1;
    step();
    check32("t2_resume_pc", if_pc, 32'hC);
    check32("t2_resume_instr", if_instr, 32'hA000_0003);

    // redirect with the FIFO full
    id_ready = 1'b0;
    repeat (2) step();
    check32("t3_occ", 32'(dut.occ), 32'd2);
    redirect(32'h0000_0103);
    id_ready = 1'b1;
    check32("t3_gap1", 32'(if_valid), 32'd0);
    step();
    check32("t3_gap2", 32'(if_valid), 32'd0);
    step();
    check32("t3_valid", 32'(if_valid), 32'd1);
    check32("t3_pc", if_pc, 32'h100);
    check32("t3_instr", if_instr, 32'hA000_0040);

    // redirect in the same cycle as a dequeue
    repeat (2) step();
    check32("t4_head", if_pc, 32'h108);
    check32("t4_occ", 32'(dut.occ), 32'd1);
    acc0 = accepted;
    redirect(32'h0000_0200);
    check32("t4_acc_once", 32'(accepted), 32'(acc0 + 1));
    check32("t4_acc_pc", last_acc_pc, 32'h108);
    check32("t4_flushed", 32'(if_valid), 32'd0);
    repeat (2) step();
    check32("t4_pc", if_pc, 32'h200);
    check32("t4_instr", if_instr, 32'hA000_0080);

    // word-address wrap at 64K
    redirect(32'h0003_FFFC);
    check32("t5_addr_top", 32'(imem_addr), 32'hFFFF);
    step();
    check32("t5_addr_wrap", 32'(imem_addr), 32'h0000);
    step();
    check32("t5_pc_top", if_pc, 32'h0003_FFFC);
    check32("t5_instr_top", if_instr, 32'hA000_FFFF);
    step();
    check32("t5_pc_wrap", if_pc, 32'h0004_0000);
    check32("t5_instr_wrap", if_instr, 32'hA000_0000);

    // reset pulse with the FIFO full
    id_ready = 1'b0;
    repeat (2) step();
    check32("t6_occ", 32'(dut.occ), 32'd2);
    rst_n    = 1'b0;
    id_ready = 1'b1;
    step();
    rst_n = 1'b1;
    check32("t6_valid_drop", 32'(if_valid), 32'd0);
    check32("t6_pc_clr", if_pc, 32'h0);
    check32("t6_addr_clr", 32'(imem_addr), 32'h0);
    step();
    check32("t6_gap", 32'(if_valid), 32'd0);
    step();
    check32("t6_pc", if_pc, 32'h0);
    check32("t6_instr", if_instr, 32'hA000_0000);

    // irregular decode backpressure, checked by the stream model
    pattern = 16'b1011_0011_1000_1101;
    for (int i = 0; i < 16; i++) begin
      id_ready = pattern[i];
      step();
    end
    id_ready = 1'b1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
